instr_trace_buf: RTL and testbench
==================================

Name: instr_trace_buf

Overview:
- Parametrised successor to the single-register tracer capture stage.
- Holds a circular window of DEPTH tracer snapshots around a trigger event: pre-trigger history plus a programmable number of post-trigger samples.
- Freezes the window after the post-trigger samples, then drains it oldest-first over a valid/ready readout port to the debug/trace unit.

Parameters:
- DATA_W, 1230, width of one tracer snapshot.
- DEPTH, 16, number of snapshot entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- capture_in  in  DATA_W  tracer snapshot.
- capture_valid_i  in  1  snapshot is valid this cycle.
- arm_i  in  1  start recording (pulse).
- abort_i  in  1  discard the window and return to IDLE.
- trig_i  in  1  trigger; only qualified when capture_valid_i=1.
- post_cnt_i  in  PTR_W  number of post-trigger samples; sampled when arm_i is accepted.
- rd_data_o  out  DATA_W  readout snapshot.
- rd_valid_o  out  1  rd_data_o is valid.
- rd_ready_i  in  1  consumer accepts rd_data_o.
- rd_last_o  out  1  current beat is the final entry of the window.
- trig_idx_o  out  PTR_W  readout index of the trigger sample.
- state_o  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rst_ni, asynchronous and active-low.
- Reset values: state IDLE; wr_ptr, fill, post_left, rd_cnt and trig_idx all 0; rd_valid_o=0; rd_last_o=0. The memory array is not reset.
- Sample write (ARMED or POST, capture_valid_i=1):
  - mem[wr_ptr] <= capture_in.
  - wr_ptr increments and wraps DEPTH-1 -> 0.
  - fill increments and saturates at DEPTH.
- IDLE:
  - Nothing is recorded.
  - arm_i=1 -> ARMED next cycle; wr_ptr=0, fill=0, post_left<=post_cnt_i.
- ARMED:
  - Records every valid sample, overwriting the oldest entry once full.
  - capture_valid_i & trig_i: the trigger sample is written in the same cycle.
  - If post_left=0 -> DONE next cycle; otherwise -> POST.
  - trig_i while capture_valid_i=0 is ignored.
- POST:
  - Each valid sample is written and post_left decrements.
  - The write that takes post_left from 1 to 0 -> DONE next cycle.
  - Further trig_i is ignored.
- Entry to DONE:
  - Readout pointer = (wr_ptr - fill) mod DEPTH, i.e. the oldest entry.
  - rd_cnt = fill.
  - trig_idx_o = fill - 1 - post_cnt (the post_cnt value latched at arm); this value is held until the next arm.
  - No writes occur in DONE.
- DONE readout:
  - rd_valid_o=1 while rd_cnt>0.
  - rd_data_o = mem[rd_ptr]. It is stable while rd_valid_o=1 and rd_ready_i=0.
  - On rd_valid_o & rd_ready_i: rd_ptr increments with wrap, rd_cnt decrements.
  - rd_last_o = rd_valid_o & (rd_cnt==1).
  - The transfer with rd_last_o=1 -> IDLE next cycle; rd_valid_o=0 from that cycle on.
- Latency:
  - The first readout beat is valid in the cycle after the DONE transition.
  - Sustains one beat per cycle while rd_ready_i=1.
- arm_i outside IDLE is ignored.
- abort_i in any state -> IDLE next cycle, rd_valid_o=0. abort_i has priority over arm_i, trig_i and any readout transfer in the same cycle.
- Clamp: post_cnt_i values above DEPTH-1 cannot occur because of its width, so the trigger sample is always retained.
- Reset asserted mid-readout or mid-recording: all outputs return to their reset values immediately (asynchronous reset).

Test Plan (DEPTH=8):
- Basic window: arm with post_cnt=2; feed valid samples 0..19; trig on sample 10 -> DONE after sample 12. Readout is samples 5..12 (8 beats), rd_last_o on 12, trig_idx_o=5.
- Short history: arm with post_cnt=1; trig on the 3rd sample (samples 0..2 written), then sample 3 -> readout 0,1,2,3 (4 beats), trig_idx_o=2.
- Back-pressure and gaps:
  - Toggle capture_valid_i during POST -> only valid samples are counted.
  - Hold rd_ready_i=0 for 5 cycles mid-readout -> rd_data_o stable, no beat lost or duplicated.
- Wrap and zero post: arm with post_cnt=0; feed 13 samples then trig on the 14th (sample 13) -> DONE immediately after it. Readout is 6..13, trig_idx_o=7, correct across the pointer wrap.
- Abort and ignored inputs:
  - abort_i during POST -> IDLE next cycle, no readout.
  - arm_i during DONE -> ignored.
  - abort_i together with rd_ready_i during DONE -> IDLE, no further beats.
- Async reset: deassert rst_ni mid-readout between clock edges -> rd_valid_o=0 and state_o=0 immediately. After release, a new arm works normally.

Source files
------------

// File: rtl/instr_trace_buf.sv
// -----------------------------------------------------------------------------
// instr_trace_buf
//
// Circular capture window for tracer snapshots around a trigger event.
// After arming, every valid snapshot is written into a DEPTH-entry ring. The
// oldest entry is overwritten once the ring is full. A qualified trigger starts
// the post-trigger countdown. When the countdown ends the window is frozen and
// drained oldest-first over a valid/ready port.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous, active-low reset
//   capture_in       tracer snapshot (DATA_W bits)
//   capture_valid_i  snapshot is valid this cycle
//   arm_i            start recording (pulse, only honoured in IDLE)
//   abort_i          discard the window and return to IDLE (highest priority)
//   trig_i           trigger, qualified by capture_valid_i
//   post_cnt_i       post-trigger sample count, latched when arm_i is accepted
//   rd_data_o        readout snapshot
//   rd_valid_o       rd_data_o is valid
//   rd_ready_i       consumer accepts rd_data_o
//   rd_last_o        current beat is the final entry of the window
//   trig_idx_o       readout index of the trigger sample
//   state_o          0=IDLE, 1=ARMED, 2=POST, 3=DONE
// -----------------------------------------------------------------------------
module instr_trace_buf #(
  parameter  int DATA_W = 1230,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] capture_in,
  input  logic              capture_valid_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              trig_i,
  input  logic [PTR_W-1:0]  post_cnt_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              rd_last_o,
  output logic [PTR_W-1:0]  trig_idx_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Fill level saturates at DEPTH, so it needs one bit more than a pointer.
  localparam logic [PTR_W:0] FILL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [1:0]        w_state_next;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_fill;
  logic [PTR_W-1:0]  r_post_left;
  logic [PTR_W-1:0]  r_post_cnt;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_rd_cnt;
  logic [PTR_W-1:0]  r_trig_idx;

  // Snapshot storage (no reset, maps onto block RAM) and its read register.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic              w_recording;
  logic              w_write;
  logic              w_arm;
  logic              w_trig;
  logic              w_post_end;
  logic              w_enter_done;
  logic              w_xfer;
  logic [PTR_W-1:0]  w_wr_ptr_inc;
  logic [PTR_W:0]    w_fill_inc;
  logic [PTR_W-1:0]  w_oldest;
  logic [PTR_W-1:0]  w_trig_idx_new;
  logic [PTR_W-1:0]  w_rd_addr;
  logic              w_rd_load;
  logic              w_bypass;

  assign w_recording = (r_state == S_ARMED) || (r_state == S_POST);

  // An aborted window is discarded, so the sample arriving with abort_i is
  // not stored either.
  assign w_write = w_recording && capture_valid_i && !abort_i;

  assign w_arm = (r_state == S_IDLE) && arm_i && !abort_i;

  // Trigger only counts on a valid sample while ARMED; later triggers are
  // ignored.
  assign w_trig = (r_state == S_ARMED) && capture_valid_i && trig_i;

  // The write that takes post_left from 1 to 0 closes the window.
  assign w_post_end = (r_state == S_POST) && capture_valid_i &&
                      (r_post_left == PTR_ONE);

  // The window always closes on a write cycle: either the trigger sample
  // itself (zero post-trigger count) or the last post-trigger sample.
  assign w_enter_done = !abort_i &&
                        ((w_trig && (r_post_left == '0)) || w_post_end);

  assign w_wr_ptr_inc = r_wr_ptr + PTR_ONE;
  assign w_fill_inc   = (r_fill == FILL_FULL) ? r_fill : (r_fill + 1'b1);

  // Pointers are power-of-two wide, so modular arithmetic is implicit. With a
  // full ring the low bits of fill are zero and the oldest entry is the next
  // write slot.
  assign w_oldest       = w_wr_ptr_inc - w_fill_inc[PTR_W-1:0];
  assign w_trig_idx_new = w_fill_inc[PTR_W-1:0] - PTR_ONE - r_post_cnt;

  assign w_xfer = rd_valid_o && rd_ready_i && !abort_i;

  // The read register is refilled on DONE entry (oldest entry) and after each
  // accepted beat (next entry). It holds otherwise, which keeps rd_data_o
  // stable under back-pressure.
  assign w_rd_load = w_enter_done || w_xfer;
  assign w_rd_addr = w_enter_done ? w_oldest : (r_rd_ptr + PTR_ONE);

  // On DONE entry the final sample is written in the same cycle. If that
  // slot is also the oldest (single-entry window) the RAM still holds stale
  // data, so forward the incoming snapshot instead.
  assign w_bypass = w_enter_done && (r_wr_ptr == w_oldest);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (arm_i) begin
          w_state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_trig) begin
          w_state_next = (r_post_left == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (w_post_end) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_xfer && (r_rd_cnt == 1)) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Abort wins over every other event in the same cycle.
    if (abort_i) begin
      w_state_next = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_valid_o = 1'b0;
    rd_last_o  = 1'b0;
    if ((r_state == S_DONE) && (r_rd_cnt != '0)) begin
      rd_valid_o = 1'b1;
      rd_last_o  = (r_rd_cnt == 1);
    end
  end

  assign state_o    = r_state;
  assign rd_data_o  = r_rd_data;
  assign trig_idx_o = r_trig_idx;

  // ---------------------------------------------------------------------------
  // Write side: pointer, fill level and post-trigger countdown
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_post_left <= '0;
      r_post_cnt  <= '0;
    end else begin
      if (w_arm) begin
        r_wr_ptr    <= '0;
        r_fill      <= '0;
        r_post_left <= post_cnt_i;
        r_post_cnt  <= post_cnt_i;
      end else if (w_write) begin
        r_wr_ptr <= w_wr_ptr_inc;
        r_fill   <= w_fill_inc;
        if (r_state == S_POST) begin
          r_post_left <= r_post_left - PTR_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: readout pointer, beat counter and trigger index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_trig_idx <= '0;
    end else begin
      if (abort_i) begin
        r_rd_cnt <= '0;
      end else if (w_arm) begin
        r_trig_idx <= '0;
      end else if (w_enter_done) begin
        r_rd_ptr   <= w_oldest;
        r_rd_cnt   <= w_fill_inc;
        r_trig_idx <= w_trig_idx_new;
      end else if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_rd_cnt <= r_rd_cnt - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot memory with registered read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= capture_in;
    end
    if (w_rd_load) begin
      r_rd_data <= w_bypass ? capture_in : r_mem[w_rd_addr];
    end
  end

endmodule

// File: tb/tb_instr_trace_buf.sv
// -----------------------------------------------------------------------------
// tb_instr_trace_buf
//
// Scoreboard bench for instr_trace_buf (DEPTH=8). The recording driver keeps a
// reference window as a plain queue of the last DEPTH valid samples. When the
// window closes, it pushes the expected readout beats. A separate monitor pops
// and compares on every accepted readout beat.
// -----------------------------------------------------------------------------
module tb_instr_trace_buf;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = $clog2(DEPTH);

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [DATA_W-1:0] capture_in = '0;
  logic              capture_valid_i = 1'b0;
  logic              arm_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              trig_i = 1'b0;
  logic [PTR_W-1:0]  post_cnt_i = '0;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              rd_ready_i = 1'b0;
  logic              rd_last_o;
  logic [PTR_W-1:0]  trig_idx_o;
  logic [1:0]        state_o;

  instr_trace_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .capture_in      (capture_in),
    .capture_valid_i (capture_valid_i),
    .arm_i           (arm_i),
    .abort_i         (abort_i),
    .trig_i          (trig_i),
    .post_cnt_i      (post_cnt_i),
    .rd_data_o       (rd_data_o),
    .rd_valid_o      (rd_valid_o),
    .rd_ready_i      (rd_ready_i),
    .rd_last_o       (rd_last_o),
    .trig_idx_o      (trig_idx_o),
    .state_o         (state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [PTR_W-1:0]  tidx;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] hist[$];
  int                n_checks = 0;
  int                n_pass   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every accepted beat against the scoreboard queue
  // ---------------------------------------------------------------------------
  initial begin
    logic              stall_prev;
    logic [DATA_W-1:0] data_prev;
    beat_t             b;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev && rd_valid_o) check("stall_hold", rd_data_o, data_prev);
      if (rd_valid_o && rd_ready_i && !abort_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", rd_data_o);
        end else begin
          b = exp_q.pop_front();
          $display("beat data=%0h last=%0b tidx=%0d", rd_data_o, rd_last_o, trig_idx_o);
          check("beat_data", rd_data_o, b.data);
          check("beat_last", rd_last_o, b.last);
          check("beat_tidx", trig_idx_o, b.tidx);
        end
      end
      stall_prev = rd_valid_o && !rd_ready_i && !abort_i;
      data_prev  = rd_data_o;
    end
  end

  task automatic arm(input int post);
    arm_i      = 1'b1;
    post_cnt_i = PTR_W'(post);
    step();
    arm_i      = 1'b0;
    post_cnt_i = PTR_W'($urandom);   // must have been latched already
  endtask

  // Records until the reference window closes, then loads the scoreboard.
  task automatic record(input int post, input int trig_k, input int vpct,
                        input bit use_idx);
    int k;
    bit trig_seen, done, v;
    int left;
    k = 0; trig_seen = 0; done = 0; left = 0;
    hist.delete();
    arm(post);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      v = ($urandom_range(99) < vpct);
      capture_valid_i = v;
      capture_in      = use_idx ? DATA_W'(k) : DATA_W'($urandom);
      if (!trig_seen) trig_i = v ? (k == trig_k) : 1'($urandom_range(1));
      else            trig_i = 1'($urandom_range(1));
      step();
      if (v) begin
        hist.push_back(capture_in);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        if (!trig_seen) begin
          if (k == trig_k) begin
            trig_seen = 1;
            left = post;
            if (left == 0) done = 1;
          end
        end else begin
          left--;
          if (left == 0) done = 1;
        end
        k++;
      end
    end
    capture_valid_i = 1'b0;
    trig_i          = 1'b0;
    check("record_done", done, 1);
    check("state_done", state_o, 3);
    check("valid_on_done", rd_valid_o, 1);
    $display("window post=%0d trig_k=%0d entries=%0d", post, trig_k, hist.size());
    if (done) begin
      for (int i = 0; i < hist.size(); i++) begin
        exp_q.push_back('{hist[i], (i == hist.size() - 1),
                          PTR_W'(hist.size() - 1 - post)});
      end
    end
  endtask

  task automatic drain(input int rpct, input int stall_after, input bit arm_poke);
    int n0, stall_cnt;
    n0 = exp_q.size();
    stall_cnt = 0;
    for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
      rd_ready_i = ($urandom_range(99) < rpct);
      if (stall_after >= 0 && (n0 - exp_q.size()) >= stall_after && stall_cnt < 5) begin
        rd_ready_i = 1'b0;
        stall_cnt++;
      end
      arm_i      = arm_poke && (cyc == 2);
      post_cnt_i = PTR_W'($urandom);
      step();
    end
    arm_i      = 1'b0;
    rd_ready_i = 1'b0;
    check("drain_complete", exp_q.size(), 0);
    step();
    check("idle_after_drain", state_o, 0);
    check("valid_low_after_drain", rd_valid_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_state", state_o, 0);
    check("rst_valid", rd_valid_o, 0);
    check("rst_last", rd_last_o, 0);
    check("rst_tidx", trig_idx_o, 0);
    rst_ni = 1'b1;
    step();

    // Basic window: expect 5..12, trig_idx 5; arm during DONE ignored
    record(2, 10, 100, 1'b1);
    drain(100, -1, 1'b1);

    // Short history: expect 0..3, trig_idx 2
    record(1, 2, 100, 1'b1);
    drain(100, -1, 1'b0);

    // Gaps during capture, 5-cycle stall mid-readout
    record(3, 5, 50, 1'b1);
    drain(100, 3, 1'b0);

    // Zero post with pointer wrap: expect 6..13, trig_idx 7
    record(0, 13, 100, 1'b1);
    drain(100, -1, 1'b0);

    // Abort during POST
    arm(3);
    for (int k = 0; k < 4; k++) begin
      capture_valid_i = 1'b1;
      capture_in      = DATA_W'(k);
      trig_i          = (k == 2);
      step();
    end
    check("post_state", state_o, 2);
    capture_valid_i = 1'b1;
    abort_i         = 1'b1;
    step();
    abort_i = 1'b0; capture_valid_i = 1'b0; trig_i = 1'b0;
    check("abort_post_state", state_o, 0);
    check("abort_post_valid", rd_valid_o, 0);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rd_ready_i = 1'b0;
    check("abort_post_stays_idle", state_o, 0);

    // Abort together with rd_ready in DONE
    record(2, 4, 100, 1'b0);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    abort_i = 1'b1;
    exp_q.delete();
    step();
    abort_i = 1'b0;
    check("abort_done_state", state_o, 0);
    check("abort_done_valid", rd_valid_o, 0);
    for (int i = 0; i < 5; i++) step();
    rd_ready_i = 1'b0;

    // Asynchronous reset mid-readout
    record(1, 9, 100, 1'b1);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    #3;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", rd_valid_o, 0);
    check("async_rst_state", state_o, 0);
    check("async_rst_last", rd_last_o, 0);
    exp_q.delete();
    rd_ready_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    record(2, 10, 100, 1'b1);
    drain(100, -1, 1'b0);

    // Randomised windows
    for (int it = 0; it < 8; it++) begin
      record($urandom_range(DEPTH - 1), $urandom_range(20),
             $urandom_range(100, 40), 1'b0);
      drain($urandom_range(100, 30), (it % 2 == 0) ? int'($urandom_range(6)) : -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
